// File: rtl/por_reset_sequencer.sv
// -----------------------------------------------------------------------------
// por_reset_sequencer
// Turns the asynchronous POR core output into a clock-synchronised, staged
// set of domain resets (IO -> core -> peripheral). Re-sequences on PLL lock
// loss, watchdog expiry and software reset request.
//
// Ports:
//   clk          free-running reference clock
//   rst_n        async active-low reset from the POR core cell
//   pll_lock     PLL lock indication, asynchronous to clk
//   sw_rst_req   software reset request (clk-synchronous, honoured in RUN)
//   wdt_expire   watchdog expiry (clk-synchronous, honoured in RUN)
//   rst_sync_n   rst_n with async assert / synchronous deassert
//   io_rst_n     IO domain reset, active-low
//   core_rst_n   core domain reset, active-low
//   periph_rst_n peripheral domain reset, active-low
//   seq_done     high only while in RUN
//   lock_timeout sticky flag: lock wait timed out (cleared only by rst_n)
//   rst_cause    last reset cause: 00 POR, 01 sw, 10 wdt, 11 lock loss
// -----------------------------------------------------------------------------
module por_reset_sequencer #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned STRETCH_CYC  = 1024,
  parameter int unsigned STAGE_GAP    = 16,
  parameter int unsigned SOFT_HOLD    = 32,
  parameter int unsigned LOCK_TIMEOUT = 4096,
  parameter int unsigned CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  input  logic       sw_rst_req,
  input  logic       wdt_expire,
  output logic       rst_sync_n,
  output logic       io_rst_n,
  output logic       core_rst_n,
  output logic       periph_rst_n,
  output logic       seq_done,
  output logic       lock_timeout,
  output logic [1:0] rst_cause
);

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STRETCH   = 3'd2,
    ST_IO_UP     = 3'd3,
    ST_CORE_UP   = 3'd4,
    ST_RUN       = 3'd5,
    ST_WDT_HOLD  = 3'd6,
    ST_SW_HOLD   = 3'd7
  } state_t;

  localparam logic [1:0] CAUSE_POR  = 2'b00;
  localparam logic [1:0] CAUSE_SW   = 2'b01;
  localparam logic [1:0] CAUSE_WDT  = 2'b10;
  localparam logic [1:0] CAUSE_LOCK = 2'b11;

  // Terminal counts: the counter starts at 0 on state entry.
  localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(SOFT_HOLD - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST    = CNT_W'(LOCK_TIMEOUT - 1);

  logic [SYNC_STAGES-1:0] rst_sync_q;
  logic [SYNC_STAGES-1:0] lock_sync_q;
  logic                   lock_s;
  state_t                 state_q;
  state_t                 state_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [1:0]             cause_d;
  logic                   set_timeout_c;
  logic                   lock_lost_c;

  // Reset synchroniser: async clear, ones shifted in after rst_n release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rst_sync_n = rst_sync_q[SYNC_STAGES-1];

  // PLL lock synchroniser.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_sync_q <= '0;
    end else begin
      lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], pll_lock};
    end
  end

  assign lock_s = lock_sync_q[SYNC_STAGES-1];

  // Lock loss only counts while the system is not running unlocked.
  assign lock_lost_c = !lock_s && !lock_timeout;

  // Next-state and cause selection.
  always_comb begin
    state_d       = state_q;
    cause_d       = rst_cause;
    set_timeout_c = 1'b0;
    case (state_q)
      ST_RESET: begin
        if (rst_sync_n) begin
          state_d = ST_WAIT_LOCK;
        end
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = ST_STRETCH;
        end else if (cnt_q == LOCK_LAST) begin
          state_d       = ST_STRETCH;
          set_timeout_c = 1'b1;
        end
      end
      ST_STRETCH: begin
        if (lock_lost_c) begin
          state_d = ST_WAIT_LOCK;
        end else if (cnt_q == STRETCH_LAST) begin
          state_d = ST_IO_UP;
        end
      end
      ST_IO_UP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_CORE_UP;
        end
      end
      ST_CORE_UP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Priority: lock loss, then watchdog, then software request.
        if (lock_lost_c) begin
          state_d = ST_WAIT_LOCK;
          cause_d = CAUSE_LOCK;
        end else if (wdt_expire) begin
          state_d = ST_WDT_HOLD;
          cause_d = CAUSE_WDT;
        end else if (sw_rst_req) begin
          state_d = ST_SW_HOLD;
          cause_d = CAUSE_SW;
        end
      end
      ST_WDT_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_WAIT_LOCK;
        end
      end
      ST_SW_HOLD: begin
        // IO stays up; only core and peripheral are re-staged.
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_CORE_UP;
        end
      end
      default: begin
        state_d = ST_RESET;
      end
    endcase
  end

  // State, counter and outputs; outputs decode the next state so they
  // switch on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RESET;
      cnt_q        <= '0;
      io_rst_n     <= 1'b0;
      core_rst_n   <= 1'b0;
      periph_rst_n <= 1'b0;
      seq_done     <= 1'b0;
      lock_timeout <= 1'b0;
      rst_cause    <= CAUSE_POR;
    end else begin
      state_q      <= state_d;
      cnt_q        <= (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
      io_rst_n     <= state_d inside {ST_IO_UP, ST_CORE_UP, ST_RUN, ST_SW_HOLD};
      core_rst_n   <= state_d inside {ST_CORE_UP, ST_RUN};
      periph_rst_n <= (state_d == ST_RUN);
      seq_done     <= (state_d == ST_RUN);
      rst_cause    <= cause_d;
      if (set_timeout_c) begin
        lock_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_por_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_por_reset_sequencer
// Randomised bench for por_reset_sequencer. Each scenario is planned as a
// timeline of output changes (edge number -> expected output word) derived
// from the sequencing rules with plain arithmetic; the timeline is then
// replayed edge by edge against the DUT.
// -----------------------------------------------------------------------------
module tb_por_reset_sequencer;

  localparam int SS  = 2;
  localparam int SC  = 8;
  localparam int SG  = 4;
  localparam int SH  = 3;
  localparam int LT  = 20;
  localparam int BIG = 1000000;

  localparam int SIG_LOCK = 0;
  localparam int SIG_SW   = 1;
  localparam int SIG_WDT  = 2;

  typedef struct {
    int         at;
    logic [7:0] v;
  } exp_t;

  typedef struct {
    int sig;
    int at;
    bit val;
  } stim_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pll_lock;
  logic       sw_rst_req;
  logic       wdt_expire;
  logic       rst_sync_n;
  logic       io_rst_n;
  logic       core_rst_n;
  logic       periph_rst_n;
  logic       seq_done;
  logic       lock_timeout;
  logic [1:0] rst_cause;
  logic [7:0] obs;

  int         n_checks = 0;
  int         n_errors = 0;
  bit         exp_lt;
  logic [1:0] exp_cause;
  logic [7:0] cur_exp;
  exp_t       exp_q[$];
  stim_t      stim_q[$];

  por_reset_sequencer #(
    .SYNC_STAGES (SS),
    .STRETCH_CYC (SC),
    .STAGE_GAP   (SG),
    .SOFT_HOLD   (SH),
    .LOCK_TIMEOUT(LT),
    .CNT_W       (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pll_lock    (pll_lock),
    .sw_rst_req  (sw_rst_req),
    .wdt_expire  (wdt_expire),
    .rst_sync_n  (rst_sync_n),
    .io_rst_n    (io_rst_n),
    .core_rst_n  (core_rst_n),
    .periph_rst_n(periph_rst_n),
    .seq_done    (seq_done),
    .lock_timeout(lock_timeout),
    .rst_cause   (rst_cause)
  );

  always #5 clk = ~clk;

  assign obs = {rst_sync_n, io_rst_n, core_rst_n, periph_rst_n,
                seq_done, lock_timeout, rst_cause};

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: observed {sync,io,core,periph,done,lt,cause}=%b expected=%b",
               tag, got, exp);
    end
  endtask

  // Output word with rst_sync_n high; seq_done tracks the peripheral domain.
  function automatic logic [7:0] mk(input bit io, input bit co, input bit pe);
    return {1'b1, io, co, pe, pe, exp_lt, exp_cause};
  endfunction

  task automatic expect_at(input int at, input logic [7:0] v);
    exp_t e;
    e.at = at;
    e.v  = v;
    exp_q.push_back(e);
  endtask

  task automatic drive_at(input int at, input int sig, input bit val);
    stim_t s;
    s.at  = at;
    s.sig = sig;
    s.val = val;
    stim_q.push_back(s);
  endtask

  task automatic apply(input stim_t s);
    case (s.sig)
      SIG_LOCK: pll_lock   = s.val;
      SIG_SW:   sw_rst_req = s.val;
      default:  wdt_expire = s.val;
    endcase
  endtask

  // Replay the planned timeline for n edges, checking after every edge.
  task automatic sweep(input string tag, input int n);
    for (int e = 1; e <= n; e++) begin
      @(posedge clk);
      #1;
      foreach (exp_q[i]) if (exp_q[i].at == e) cur_exp = exp_q[i].v;
      check_eq($sformatf("%s@%0d", tag, e), obs, cur_exp);
      foreach (stim_q[i]) if (stim_q[i].at == e) apply(stim_q[i]);
    end
    exp_q.delete();
    stim_q.delete();
  endtask

  // Plan from entry into the lock wait at edge w. v is the first edge at
  // which a synchronised lock is visible. g >= 0 plants a one-cycle lock
  // glitch g cycles into the stretch.
  task automatic plan_from_wait(input int w, input int v, input int g, output int t_run);
    int x;
    bit to;
    x  = (v > w + 1) ? v : w + 1;
    to = (x > w + LT);
    if (to) begin
      x      = w + LT;
      exp_lt = 1'b1;
      expect_at(x, mk(1'b0, 1'b0, 1'b0));
    end
    if (g >= 0 && !exp_lt) begin
      drive_at(x + g, SIG_LOCK, 1'b0);
      drive_at(x + g + 1, SIG_LOCK, 1'b1);
      // Glitch seen 3 edges later, lock back one edge after that.
      x = x + g + 4;
    end
    expect_at(x + SC, mk(1'b1, 1'b0, 1'b0));
    expect_at(x + SC + SG, mk(1'b1, 1'b1, 1'b0));
    t_run = x + SC + 2 * SG;
    expect_at(t_run, mk(1'b1, 1'b1, 1'b1));
  endtask

  // Power-on: k = edge after which pll_lock rises (0: already high, <0: never).
  task automatic por(input string tag, input int k, input int stop);
    int v;
    int t_run;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq($sformatf("%s_async_clear", tag), obs, 8'h00);
    sw_rst_req = 1'b0;
    wdt_expire = 1'b0;
    pll_lock   = (k == 0);
    exp_lt     = 1'b0;
    exp_cause  = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    check_eq($sformatf("%s_held", tag), obs, 8'h00);
    rst_n   = 1'b1;
    cur_exp = 8'h00;
    expect_at(SS, 8'h80);
    if (k > 0) drive_at(k, SIG_LOCK, 1'b1);
    v = (k == 0) ? SS + 1 : ((k < 0) ? BIG : k + SS + 1);
    plan_from_wait(SS + 1, v, -1, t_run);
    sweep(tag, (stop > 0) ? stop : t_run + 2);
  endtask

  // One event while in RUN: 0 sw pulse, 1 sw held, 2 wdt, 3 wdt+sw, 4 lock drop.
  task automatic run_event(input int kind, input int r, input int g);
    int  t_run;
    bit  lv;
    case (kind)
      0: begin
        sw_rst_req = 1'b1;
        drive_at(1, SIG_SW, 1'b0);
        exp_cause = 2'b01;
        expect_at(1, mk(1'b1, 1'b0, 1'b0));
        expect_at(1 + SH, mk(1'b1, 1'b1, 1'b0));
        t_run = 1 + SH + SG;
        expect_at(t_run, mk(1'b1, 1'b1, 1'b1));
        sweep("sw_pulse", t_run + 2);
      end
      1: begin
        sw_rst_req = 1'b1;
        exp_cause  = 2'b01;
        t_run      = 1 + SH + SG;
        expect_at(1, mk(1'b1, 1'b0, 1'b0));
        expect_at(1 + SH, mk(1'b1, 1'b1, 1'b0));
        expect_at(t_run, mk(1'b1, 1'b1, 1'b1));
        expect_at(t_run + 1, mk(1'b1, 1'b0, 1'b0));
        expect_at(t_run + 1 + SH, mk(1'b1, 1'b1, 1'b0));
        expect_at(t_run + 1 + SH + SG, mk(1'b1, 1'b1, 1'b1));
        drive_at(t_run + 1, SIG_SW, 1'b0);
        sweep("sw_level", t_run + 1 + SH + SG + 2);
      end
      2, 3: begin
        wdt_expire = 1'b1;
        sw_rst_req = (kind == 3);
        drive_at(1, SIG_WDT, 1'b0);
        drive_at(1, SIG_SW, 1'b0);
        exp_cause = 2'b10;
        expect_at(1, mk(1'b0, 1'b0, 1'b0));
        plan_from_wait(1 + SH, pll_lock ? 0 : BIG, -1, t_run);
        sweep((kind == 3) ? "wdt_and_sw" : "wdt", t_run + 2);
      end
      default: begin
        if (!exp_lt) begin
          pll_lock  = 1'b0;
          exp_cause = 2'b11;
          expect_at(SS + 1, mk(1'b0, 1'b0, 1'b0));
          drive_at(r, SIG_LOCK, 1'b1);
          plan_from_wait(SS + 1, r + SS + 1, g, t_run);
          sweep((g >= 0) ? "lock_loss_glitch" : "lock_loss", t_run + 2);
        end else begin
          // Running unlocked: lock toggling must leave everything alone.
          lv = pll_lock;
          drive_at(2, SIG_LOCK, !lv);
          drive_at(3, SIG_LOCK, lv);
          drive_at(5, SIG_LOCK, !lv);
          drive_at(8, SIG_LOCK, lv);
          sweep("unlocked_toggle", 12);
        end
      end
    endcase
  endtask

  initial begin
    int k;
    int kind;
    int r;
    int g;
    rst_n      = 1'b0;
    pll_lock   = 1'b0;
    sw_rst_req = 1'b0;
    wdt_expire = 1'b0;
    exp_lt     = 1'b0;
    exp_cause  = 2'b00;
    cur_exp    = 8'h00;
    repeat (2) @(posedge clk);

    por("por_locked", 0, 0);
    run_event(0, 0, -1);
    run_event(3, 0, -1);
    run_event(4, 6, 2);
    run_event(1, 0, -1);
    run_event(2, 0, -1);

    por("por_nolock", -1, 0);
    run_event(4, 0, -1);
    run_event(2, 0, -1);
    run_event(0, 0, -1);

    // Abort during IO_UP (with the sticky timeout set), then a clean POR.
    por("por_mid_io", -1, SS + 1 + LT + SC + 1);
    por("por_after_abort", 0, 0);

    for (int i = 0; i < 6; i++) begin
      k = int'($urandom_range(0, 26));
      por($sformatf("por_rand%0d", i), k, 0);
      for (int j = 0; j < 5; j++) begin
        kind = int'($urandom_range(0, 4));
        r    = int'($urandom_range(3, LT + 5));
        g    = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, SC - 4)) : -1;
        run_event(kind, r, g);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
